// File: rtl/player_anim_controller.sv
// player_anim_controller: sequences one player's sprite state and frame index.
//   Inputs : clk, rst_n (async, active-low), frame_tick (one pulse per video
//            frame), move_left/move_right (levels), atk_req (pulse or level).
//   Outputs: anim_state (0 idle, 1 move, 3 attack), anim_frame, facing_right,
//            atk_busy, hit_active, atk_done (one-cycle pulse).
//   Visible state only moves on frame_tick; atk_done self-clears a clock later.
module player_anim_controller #(
    parameter int HOLD_TICKS  = 4,
    parameter int IDLE_FRAMES = 10,
    parameter int RUN_FRAMES  = 8,
    parameter int ATK_FRAMES  = 18,
    parameter int HIT_FIRST   = 8,
    parameter int HIT_LAST    = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       atk_req,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       facing_right,
    output logic       atk_busy,
    output logic       hit_active,
    output logic       atk_done
);
    typedef enum logic [3:0] {S_IDLE = 4'd0, S_MOVE = 4'd1, S_ATK1 = 4'd3} state_t;

    localparam logic [5:0] HOLD_LAST = 6'(HOLD_TICKS - 1);
    localparam logic [5:0] IDLE_LAST = 6'(IDLE_FRAMES - 1);
    localparam logic [5:0] RUN_LAST  = 6'(RUN_FRAMES - 1);
    localparam logic [5:0] ATK_LAST  = 6'(ATK_FRAMES - 1);
    localparam logic [5:0] HIT_LO    = 6'(HIT_FIRST);
    localparam logic [5:0] HIT_HI    = 6'(HIT_LAST);

    state_t     state_q, state_d;
    logic [5:0] frame_q, frame_d, hold_q, hold_d, wrap_last;
    logic       facing_q, facing_d, busy_q, busy_d, hit_q, hit_d;
    logic       done_q, done_d, pending_q, pending_d, move, hold_wrap;

    always_comb begin
        move      = move_left ^ move_right;
        hold_wrap = hold_q == HOLD_LAST;
        wrap_last = state_q == S_MOVE ? RUN_LAST : IDLE_LAST;
        state_d   = state_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        facing_d  = facing_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // requests seen while busy are dropped, never queued
        pending_d = pending_q | (atk_req & ~busy_q);
        if (frame_tick) begin
            if (!busy_q) begin
                pending_d = 1'b0;
                facing_d  = (move_right & ~move_left) ? 1'b1 :
                            (move_left & ~move_right) ? 1'b0 : facing_q;
                if (pending_q || atk_req) begin
                    state_d = S_ATK1;
                    frame_d = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end else if (move && state_q != S_MOVE) begin
                    state_d = S_MOVE;
                    frame_d = '0;
                    hold_d  = '0;
                end else if (!move && state_q != S_IDLE) begin
                    state_d = S_IDLE;
                    frame_d = '0;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_wrap ? 6'd0 : hold_q + 6'd1;
                    frame_d = !hold_wrap ? frame_q : frame_q == wrap_last ? 6'd0 : frame_q + 6'd1;
                end
            end else if (hold_wrap && frame_q == ATK_LAST) begin
                state_d = move ? S_MOVE : S_IDLE;
                frame_d = '0;
                hold_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                hold_d  = hold_wrap ? 6'd0 : hold_q + 6'd1;
                frame_d = hold_wrap ? frame_q + 6'd1 : frame_q;
            end
        end
        hit_d = busy_d && frame_d >= HIT_LO && frame_d <= HIT_HI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            hold_q    <= '0;
            facing_q  <= 1'b1;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            hold_q    <= hold_d;
            facing_q  <= facing_d;
            busy_q    <= busy_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    assign anim_state   = state_q;
    assign anim_frame   = frame_q;
    assign facing_right = facing_q;
    assign atk_busy     = busy_q;
    assign hit_active   = hit_q;
    assign atk_done     = done_q;
endmodule

// File: tb/tb_player_anim_controller.sv
// tb_player_anim_controller: table, directed and random checks against a tick-count model.
module tb_player_anim_controller;
    localparam int HOLD = 4, IDLE_N = 10, RUN_N = 8, ATK_N = 18, HF = 8, HL = 11;

    logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
    logic       move_left = 1'b0, move_right = 1'b0, atk_req = 1'b0;
    logic [3:0] anim_state;
    logic [5:0] anim_frame;
    logic       facing_right, atk_busy, hit_active, atk_done;

    player_anim_controller #(
        .HOLD_TICKS(HOLD), .IDLE_FRAMES(IDLE_N), .RUN_FRAMES(RUN_N),
        .ATK_FRAMES(ATK_N), .HIT_FIRST(HF), .HIT_LAST(HL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .atk_req(atk_req),
        .anim_state(anim_state), .anim_frame(anim_frame), .facing_right(facing_right),
        .atk_busy(atk_busy), .hit_active(hit_active), .atk_done(atk_done)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    // model: frames derived from tick counts since entering the state / attack
    int m_state, m_e, m_t;
    bit m_busy, m_face, m_pend, m_done;

    function automatic int m_frame();
        return m_busy ? m_t / HOLD : (m_e / HOLD) % (m_state == 1 ? RUN_N : IDLE_N);
    endfunction

    function automatic logic [13:0] m_pack();
        int f = m_frame();
        return {4'(m_state), 6'(f), m_face, m_busy, 1'(m_busy && f >= HF && f <= HL), m_done};
    endfunction

    task automatic m_reset();
        m_state = 0; m_e = 0; m_t = 0; m_busy = 0; m_face = 1; m_pend = 0; m_done = 0;
    endtask

    task automatic m_step(input bit tk, input bit l, input bit r, input bit q);
        bit mv = l ^ r;
        m_done = 0;
        if (tk) begin
            if (!m_busy) begin
                if (r && !l) m_face = 1;
                else if (l && !r) m_face = 0;
                if (m_pend || q) begin m_busy = 1; m_t = 0; m_state = 3; m_pend = 0; end
                else if (mv && m_state != 1) begin m_state = 1; m_e = 0; end
                else if (!mv && m_state != 0) begin m_state = 0; m_e = 0; end
                else m_e++;
            end else if (m_t == ATK_N * HOLD - 1) begin
                m_busy = 0; m_state = mv ? 1 : 0; m_e = 0; m_done = 1;
            end else m_t++;
        end else if (q && !m_busy) m_pend = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_pack();
        return {anim_state, anim_frame, facing_right, atk_busy, hit_active, atk_done};
    endfunction

    task automatic cyc(input bit tk, input bit l, input bit r, input bit q);
        frame_tick = tk; move_left = l; move_right = r; atk_req = q;
        @(posedge clk);
        m_step(tk, l, r, q);
        #1;
        chk("model", int'(dut_pack()), int'(m_pack()));
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        frame_tick = 0; move_left = 0; move_right = 0; atk_req = 0;
        m_reset();
        #1 chk("async_reset", int'(dut_pack()), int'(14'b0000_000000_1_0_0_0));
        @(negedge clk) rst_n = 1'b1;
    endtask

    typedef struct {
        bit tk, l, r, q;
        int st, fr;
        bit face, busy;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 0, 1, 0, 1, 0, 1, 0};
        tbl[1] = '{1, 0, 1, 0, 1, 0, 1, 0};
        tbl[2] = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 1, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 0, 1, 1, 0, 0};
        tbl[6] = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 0};

        m_reset();
        repeat (3) @(posedge clk);
        #1 chk("reset_values", int'(dut_pack()), int'(14'b0000_000000_1_0_0_0));
        @(negedge clk) rst_n = 1'b1;

        // idle wrap: frame k/4 mod 10, back to 0 on tick 40
        for (int k = 1; k <= 40; k++) begin
            cyc(1, 0, 0, 0);
            chk("idle_frame", int'(anim_frame), (k / 4) % 10);
            chk("idle_state", int'(anim_state), 0);
            cyc(0, 0, 0, 0);
        end

        // move / facing table
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].tk, tbl[i].l, tbl[i].r, tbl[i].q);
            chk("tbl_row", int'({anim_state, anim_frame, facing_right, atk_busy}),
                int'({4'(tbl[i].st), 6'(tbl[i].fr), tbl[i].face, tbl[i].busy}));
        end

        // attack with request pulsed between ticks, left held and req spammed during it
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("atk_start", int'({anim_state, anim_frame, atk_busy, facing_right}), int'({4'd3, 6'd0, 1'b1, 1'b1}));
        for (int k = 1; k < 72; k++) begin
            cyc(0, 1, 0, k % 10 == 5);
            cyc(1, 1, 0, 0);
            chk("atk_hit", int'(hit_active), int'(k >= 32 && k <= 47));
            chk("atk_frozen", int'({anim_state, facing_right, atk_busy, atk_done}), int'({4'd3, 1'b1, 1'b1, 1'b0}));
            chk("atk_frame", int'(anim_frame), k / 4);
        end
        cyc(1, 1, 0, 0);
        chk("atk_end", int'({anim_state, facing_right, atk_busy, atk_done, hit_active}), int'({4'd1, 1'b1, 1'b0, 1'b1, 1'b0}));
        cyc(0, 1, 0, 0);
        chk("done_clear", int'(atk_done), 0);
        cyc(1, 1, 0, 0);
        chk("face_after", int'({anim_state, facing_right, atk_busy}), int'({4'd1, 1'b0, 1'b0}));

        // same-cycle request and tick
        cyc(1, 0, 0, 1);
        chk("same_cycle", int'({anim_state, atk_busy}), int'({4'd3, 1'b1}));
        repeat (10) cyc(1, 0, 0, 0);

        // reset mid-attack, then first ticks afterwards
        async_reset();
        cyc(1, 0, 0, 0);
        chk("post_rst_tick", int'({anim_state, anim_frame}), 0);
        repeat (3) cyc(1, 0, 0, 0);
        chk("post_rst_frame", int'(anim_frame), 1);

        // pending request is lost across a reset
        cyc(0, 0, 0, 1);
        async_reset();
        cyc(1, 0, 0, 0);
        chk("pend_cleared", int'({anim_state, atk_busy}), 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit l = ($urandom % 4) != 0 ? move_left  : 1'($urandom);
            bit r = ($urandom % 4) != 0 ? move_right : 1'($urandom);
            cyc(($urandom % 3) == 0, l, r, ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
